// File: rtl/rf_read_stage.sv
// rtl/rf_read_stage.sv - operand-fetch stage with EX/MEM/WB forwarding and load-use stall
//
// Purpose:
//   Sits between decode and execute, directly upstream of the register file
//   read ports. It drives the read addresses and resolves each source operand
//   from the youngest in-flight producer. It stalls while that producer's value
//   is not yet available, and captures the result into a single-entry
//   valid/ready pipeline register that feeds execute.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   flush                   drop the held and the incoming instruction
//   in_valid / in_ready     decode handshake
//   in_raddr1/2, in_waddr   source and destination register indices
//   in_wen, in_ctrl         destination write enable, opaque control bundle
//   rf_raddr1/2             register file read addresses (combinational)
//   rf_rdata1/2             register file read data (combinational)
//   ex_*, mem_*, wb_*       forwarding sources: valid+write, index, data, ready
//   out_valid / out_ready   execute handshake
//   out_rdata1/2            resolved operands
//   out_waddr, out_wen      registered destination and write enable
//   out_ctrl                registered control bundle

module rf_read_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CTRL_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,

  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_raddr1,
  input  logic [ADDR_WIDTH-1:0] in_raddr2,
  input  logic [ADDR_WIDTH-1:0] in_waddr,
  input  logic                  in_wen,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,

  output logic [ADDR_WIDTH-1:0] rf_raddr1,
  output logic [ADDR_WIDTH-1:0] rf_raddr2,
  input  logic [DATA_WIDTH-1:0] rf_rdata1,
  input  logic [DATA_WIDTH-1:0] rf_rdata2,

  input  logic                  ex_wen,
  input  logic [ADDR_WIDTH-1:0] ex_waddr,
  input  logic                  ex_data_ok,
  input  logic [DATA_WIDTH-1:0] ex_wdata,

  input  logic                  mem_wen,
  input  logic [ADDR_WIDTH-1:0] mem_waddr,
  input  logic                  mem_data_ok,
  input  logic [DATA_WIDTH-1:0] mem_wdata,

  input  logic                  wb_wen,
  input  logic [ADDR_WIDTH-1:0] wb_waddr,
  input  logic [DATA_WIDTH-1:0] wb_wdata,

  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_rdata1,
  output logic [DATA_WIDTH-1:0] out_rdata2,
  output logic [ADDR_WIDTH-1:0] out_waddr,
  output logic                  out_wen,
  output logic [CTRL_WIDTH-1:0] out_ctrl
);

  // A stage only forwards to a source when it actually writes that register.
  // r0 never matches: it reads as zero regardless of what any stage claims.
  function automatic logic src_hit(input logic                  s_wen,
                                   input logic [ADDR_WIDTH-1:0] s_waddr,
                                   input logic [ADDR_WIDTH-1:0] raddr);
    return s_wen && (s_waddr == raddr) && (raddr != '0);
  endfunction

  logic                  ex_hit1, mem_hit1, wb_hit1;
  logic                  ex_hit2, mem_hit2, wb_hit2;
  logic [DATA_WIDTH-1:0] opnd1, opnd2;
  logic                  hazard1, hazard2, hazard;
  logic                  accept;

  assign rf_raddr1 = in_raddr1;
  assign rf_raddr2 = in_raddr2;

  assign ex_hit1  = src_hit(ex_wen,  ex_waddr,  in_raddr1);
  assign mem_hit1 = src_hit(mem_wen, mem_waddr, in_raddr1);
  assign wb_hit1  = src_hit(wb_wen,  wb_waddr,  in_raddr1);
  assign ex_hit2  = src_hit(ex_wen,  ex_waddr,  in_raddr2);
  assign mem_hit2 = src_hit(mem_wen, mem_waddr, in_raddr2);
  assign wb_hit2  = src_hit(wb_wen,  wb_waddr,  in_raddr2);

  // Youngest producer wins. WB must still be forwarded because the register
  // file commits at the same edge, so its read port returns the old value.
  always_comb begin
    opnd1 = rf_rdata1;
    if (in_raddr1 == '0)   opnd1 = '0;
    else if (ex_hit1)      opnd1 = ex_wdata;
    else if (mem_hit1)     opnd1 = mem_wdata;
    else if (wb_hit1)      opnd1 = wb_wdata;
  end

  always_comb begin
    opnd2 = rf_rdata2;
    if (in_raddr2 == '0)   opnd2 = '0;
    else if (ex_hit2)      opnd2 = ex_wdata;
    else if (mem_hit2)     opnd2 = mem_wdata;
    else if (wb_hit2)      opnd2 = wb_wdata;
  end

  // A not-yet-ready EX producer shadows any MEM copy of the same register:
  // the MEM value is older and would be wrong even if it is available.
  assign hazard1 = (ex_hit1 && !ex_data_ok) || (!ex_hit1 && mem_hit1 && !mem_data_ok);
  assign hazard2 = (ex_hit2 && !ex_data_ok) || (!ex_hit2 && mem_hit2 && !mem_data_ok);
  assign hazard  = hazard1 || hazard2;

  assign in_ready = !flush && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Single-entry output register. Payload only changes on accept, so it is
  // naturally stable while execute applies backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_rdata1 <= '0;
      out_rdata2 <= '0;
      out_waddr  <= '0;
      out_wen    <= 1'b0;
      out_ctrl   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_rdata1 <= opnd1;
      out_rdata2 <= opnd2;
      out_waddr  <= in_waddr;
      out_wen    <= in_wen;
      out_ctrl   <= in_ctrl;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_read_stage.sv
// tb/tb_rf_read_stage.sv - scoreboard bench for rf_read_stage

module tb_rf_read_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_raddr1 = '0, in_raddr2 = '0, in_waddr = '0;
  logic        in_wen = 1'b0;
  logic [31:0] in_ctrl = '0;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        ex_wen = 1'b0, ex_data_ok = 1'b1;
  logic [4:0]  ex_waddr = '0;
  logic [31:0] ex_wdata = '0;
  logic        mem_wen = 1'b0, mem_data_ok = 1'b1;
  logic [4:0]  mem_waddr = '0;
  logic [31:0] mem_wdata = '0;
  logic        wb_wen = 1'b0;
  logic [4:0]  wb_waddr = '0;
  logic [31:0] wb_wdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_rdata1, out_rdata2;
  logic [4:0]  out_waddr;
  logic        out_wen;
  logic [31:0] out_ctrl;

  logic [31:0] rf_mem [32];
  assign rf_rdata1 = rf_mem[rf_raddr1];
  assign rf_rdata2 = rf_mem[rf_raddr2];

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  wa;
    logic        wen;
    logic [31:0] ctrl;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  rf_read_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_raddr1(in_raddr1), .in_raddr2(in_raddr2), .in_waddr(in_waddr),
    .in_wen(in_wen), .in_ctrl(in_ctrl),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .ex_wen(ex_wen), .ex_waddr(ex_waddr), .ex_data_ok(ex_data_ok), .ex_wdata(ex_wdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_data_ok(mem_data_ok), .mem_wdata(mem_wdata),
    .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rdata1(out_rdata1), .out_rdata2(out_rdata2),
    .out_waddr(out_waddr), .out_wen(out_wen), .out_ctrl(out_ctrl)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshake on the output side pops one expected entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got ctrl 0x%08h expected no transfer", out_ctrl);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_rdata1", out_rdata1, e.d1);
        check("out_rdata2", out_rdata2, e.d2);
        check("out_waddr", {27'd0, out_waddr}, {27'd0, e.wa});
        check("out_wen", {31'd0, out_wen}, {31'd0, e.wen});
        check("out_ctrl", out_ctrl, e.ctrl);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_fwd();
    ex_wen = 0; ex_waddr = 0; ex_data_ok = 1; ex_wdata = 0;
    mem_wen = 0; mem_waddr = 0; mem_data_ok = 1; mem_wdata = 0;
    wb_wen = 0; wb_waddr = 0; wb_wdata = 0;
  endtask

  task automatic set_in(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] wa,
                        input logic wen, input logic [31:0] ctrl);
    in_valid = 1; in_raddr1 = r1; in_raddr2 = r2; in_waddr = wa; in_wen = wen; in_ctrl = ctrl;
  endtask

  // Presents one instruction that must be accepted this cycle.
  task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] wa,
                       input logic wen, input logic [31:0] ctrl,
                       input logic [31:0] e1, input logic [31:0] e2);
    exp_t e;
    set_in(r1, r2, wa, wen, ctrl);
    #1;
    check("in_ready_accept", {31'd0, in_ready}, 32'd1);
    e.d1 = e1; e.d2 = e2; e.wa = wa; e.wen = wen; e.ctrl = ctrl;
    exp_q.push_back(e);
    step();
    in_valid = 0;
  endtask

  initial begin
    exp_t dropped;
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h1000 + i;
    rf_mem[0] = 32'hDEAD_BEEF;
    rf_mem[3] = 32'h11;
    rf_mem[4] = 32'h22;
    rf_mem[7] = 32'h0;

    #1 rst_n = 0;
    step();
    step();
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_rdata1", out_rdata1, 32'd0);
    check("reset_out_ctrl", out_ctrl, 32'd0);
    @(negedge clk);
    rst_n = 1;
    step();

    // Plain read through the register file.
    set_in(5'd3, 5'd4, 5'd1, 1'b1, 32'h101);
    #1;
    check("rf_raddr1", {27'd0, rf_raddr1}, 32'd3);
    check("rf_raddr2", {27'd0, rf_raddr2}, 32'd4);
    issue(5'd3, 5'd4, 5'd1, 1'b1, 32'h101, 32'h11, 32'h22);

    // r0 reads as zero even with a matching EX write to r0.
    ex_wen = 1; ex_waddr = 0; ex_wdata = 32'hFF;
    issue(5'd0, 5'd4, 5'd2, 1'b0, 32'h102, 32'h0, 32'h22);

    // EX beats MEM beats WB.
    clr_fwd();
    ex_wen = 1;  ex_waddr = 5;  ex_wdata = 32'hA;
    mem_wen = 1; mem_waddr = 5; mem_wdata = 32'hB;
    wb_wen = 1;  wb_waddr = 5;  wb_wdata = 32'hC;
    issue(5'd6, 5'd5, 5'd3, 1'b1, 32'h103, 32'h1006, 32'hA);

    // MEM beats WB once EX no longer writes.
    ex_wen = 0;
    issue(5'd5, 5'd5, 5'd4, 1'b1, 32'h104, 32'hB, 32'hB);

    // WB bypass over a stale register file value.
    clr_fwd();
    wb_wen = 1; wb_waddr = 7; wb_wdata = 32'h1234;
    issue(5'd7, 5'd3, 5'd5, 1'b1, 32'h105, 32'h1234, 32'h11);

    // Ready EX value shadows a not-ready MEM producer: no stall.
    clr_fwd();
    ex_wen = 1;  ex_waddr = 8;  ex_wdata = 32'h88;
    mem_wen = 1; mem_waddr = 8; mem_data_ok = 0;
    issue(5'd8, 5'd0, 5'd6, 1'b0, 32'h106, 32'h88, 32'h0);

    // Load-use: EX load not ready stalls, even with a ready MEM copy.
    clr_fwd();
    ex_wen = 1;  ex_waddr = 9;  ex_data_ok = 0;
    mem_wen = 1; mem_waddr = 9; mem_wdata = 32'h99;
    set_in(5'd3, 5'd9, 5'd7, 1'b1, 32'h107);
    #1;
    check("stall_in_ready_c0", {31'd0, in_ready}, 32'd0);
    check("stall_prev_held", {31'd0, out_valid}, 32'd1);
    for (int c = 1; c <= 2; c++) begin
      step();
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_out_valid", {31'd0, out_valid}, 32'd0);
    end
    clr_fwd();
    mem_wen = 1; mem_waddr = 9; mem_wdata = 32'h55;
    issue(5'd3, 5'd9, 5'd7, 1'b1, 32'h107, 32'h11, 32'h55);

    // MEM producer still waiting on its load response also stalls.
    clr_fwd();
    mem_wen = 1; mem_waddr = 10; mem_data_ok = 0;
    set_in(5'd10, 5'd4, 5'd8, 1'b1, 32'h108);
    step();
    check("mem_stall_in_ready", {31'd0, in_ready}, 32'd0);
    mem_data_ok = 1; mem_wdata = 32'h77;
    issue(5'd10, 5'd4, 5'd8, 1'b1, 32'h108, 32'h77, 32'h22);
    clr_fwd();

    // Backpressure: held output is stable, then back-to-back transfers.
    issue(5'd3, 5'd4, 5'd2, 1'b1, 32'hA0, 32'h11, 32'h22);
    out_ready = 0;
    set_in(5'd4, 5'd3, 5'd9, 1'b0, 32'hB0);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_rdata1", out_rdata1, 32'h11);
      check("bp_out_ctrl", out_ctrl, 32'hA0);
      step();
    end
    out_ready = 1;
    issue(5'd4, 5'd3, 5'd9, 1'b0, 32'hB0, 32'h22, 32'h11);
    check("b2b_ctrl_b", out_ctrl, 32'hB0);
    issue(5'd7, 5'd0, 5'd10, 1'b1, 32'hC0, 32'h0, 32'h0);
    check("b2b_ctrl_c", out_ctrl, 32'hC0);
    check("b2b_valid", {31'd0, out_valid}, 32'd1);

    // Flush with a held instruction and a valid incoming one.
    issue(5'd3, 5'd3, 5'd11, 1'b1, 32'hD0, 32'h11, 32'h11);
    out_ready = 0;
    set_in(5'd4, 5'd4, 5'd12, 1'b1, 32'hE0);
    flush = 1;
    #1;
    check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    dropped = exp_q.pop_back();
    flush = 0; in_valid = 0; out_ready = 1;
    step();

    // Asynchronous reset while holding an instruction.
    issue(5'd4, 5'd3, 5'd13, 1'b1, 32'hF0, 32'h22, 32'h11);
    out_ready = 0;
    #2;
    rst_n = 0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_out_rdata1", out_rdata1, 32'd0);
    check("arst_out_rdata2", out_rdata2, 32'd0);
    check("arst_out_waddr", {27'd0, out_waddr}, 32'd0);
    check("arst_out_wen", {31'd0, out_wen}, 32'd0);
    check("arst_out_ctrl", out_ctrl, 32'd0);
    dropped = exp_q.pop_back();
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    step();

    // Recovery after reset.
    issue(5'd3, 5'd4, 5'd14, 1'b1, 32'h1F0, 32'h11, 32'h22);
    for (int c = 0; c < 4; c++) step();
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
